// File: rtl/minirisc_core.sv
// Multi-cycle accumulator core: IDLE -> EXEC -> DONE per instruction.
// Optional multiplier (opcode C) enabled by the MINIRISC_MUL_EN macro.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   instr_valid/ready handshake (ready only in IDLE)
//   opcode, reg_sel, imm  instruction fields, latched on accept
//   acc, flag_z, flag_c   architectural state (registered)
//   done, err         one-cycle pulses during DONE
//   state             FSM state code
module minirisc_core #(
  parameter int DATA_W = 8,
  parameter int NREG   = 4,
  localparam int RW    = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        opcode,
  input  logic [RW-1:0]     reg_sel,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] acc,
  output logic              flag_z,
  output logic              flag_c,
  output logic              done,
  output logic              err,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_SUBI = 4'h3;
  localparam logic [3:0] OP_STR  = 4'h4;
  localparam logic [3:0] OP_LDR  = 4'h5;
  localparam logic [3:0] OP_ADDR = 4'h6;
  localparam logic [3:0] OP_INC  = 4'h7;
  localparam logic [3:0] OP_DEC  = 4'h8;
  localparam logic [3:0] OP_ANDI = 4'h9;
  localparam logic [3:0] OP_ORI  = 4'hA;
  localparam logic [3:0] OP_XORI = 4'hB;
`ifdef MINIRISC_MUL_EN
  localparam logic [3:0] OP_MULI = 4'hC;
`endif

  state_t              state_q;
  logic [3:0]          op_q;
  logic [RW-1:0]       sel_q;
  logic [DATA_W-1:0]   imm_q;
  logic [DATA_W-1:0]   acc_q;
  logic                z_q;
  logic                c_q;
  logic                done_q;
  logic                err_q;
  logic [DATA_W-1:0]   regs_q [NREG];

  logic [DATA_W-1:0]   res_d;
  logic                c_d;
  logic [DATA_W:0]     sum;
  logic                wr_acc;
  logic                wr_c;
  logic                wr_reg;
  logic                ill;
`ifdef MINIRISC_MUL_EN
  logic [2*DATA_W-1:0] prod;
`endif

  assign instr_ready = (state_q == S_IDLE);
  assign acc         = acc_q;
  assign flag_z      = z_q;
  assign flag_c      = c_q;
  assign done        = done_q;
  assign err         = err_q;
  assign state       = state_q;

  // Result of the latched instruction, consumed at the EXEC edge.
  always_comb begin
    res_d  = acc_q;
    c_d    = c_q;
    sum    = '0;
    wr_acc = 1'b0;
    wr_c   = 1'b0;
    wr_reg = 1'b0;
    ill    = 1'b0;
`ifdef MINIRISC_MUL_EN
    prod   = '0;
`endif
    case (op_q)
      OP_NOP: ;
      OP_LDI: begin
        res_d  = imm_q;
        wr_acc = 1'b1;
      end
      OP_ADDI: begin
        sum    = {1'b0, acc_q} + {1'b0, imm_q};
        res_d  = sum[DATA_W-1:0];
        c_d    = sum[DATA_W];
        wr_acc = 1'b1;
        wr_c   = 1'b1;
      end
      OP_SUBI: begin
        // top bit of the widened difference is the borrow
        sum    = {1'b0, acc_q} - {1'b0, imm_q};
        res_d  = sum[DATA_W-1:0];
        c_d    = sum[DATA_W];
        wr_acc = 1'b1;
        wr_c   = 1'b1;
      end
      OP_STR: wr_reg = 1'b1;
      OP_LDR: begin
        res_d  = regs_q[sel_q];
        wr_acc = 1'b1;
      end
      OP_ADDR: begin
        sum    = {1'b0, acc_q} + {1'b0, regs_q[sel_q]};
        res_d  = sum[DATA_W-1:0];
        c_d    = sum[DATA_W];
        wr_acc = 1'b1;
        wr_c   = 1'b1;
      end
      OP_INC: begin
        sum    = {1'b0, acc_q} + (DATA_W+1)'(1);
        res_d  = sum[DATA_W-1:0];
        c_d    = sum[DATA_W];
        wr_acc = 1'b1;
        wr_c   = 1'b1;
      end
      OP_DEC: begin
        sum    = {1'b0, acc_q} - (DATA_W+1)'(1);
        res_d  = sum[DATA_W-1:0];
        c_d    = sum[DATA_W];
        wr_acc = 1'b1;
        wr_c   = 1'b1;
      end
      OP_ANDI: begin
        res_d  = acc_q & imm_q;
        wr_acc = 1'b1;
      end
      OP_ORI: begin
        res_d  = acc_q | imm_q;
        wr_acc = 1'b1;
      end
      OP_XORI: begin
        res_d  = acc_q ^ imm_q;
        wr_acc = 1'b1;
      end
`ifdef MINIRISC_MUL_EN
      OP_MULI: begin
        prod   = {{DATA_W{1'b0}}, acc_q}
               * {{DATA_W{1'b0}}, imm_q};
        res_d  = prod[DATA_W-1:0];
        c_d    = |prod[2*DATA_W-1:DATA_W];
        wr_acc = 1'b1;
        wr_c   = 1'b1;
      end
`endif
      default: ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      sel_q   <= '0;
      imm_q   <= '0;
      acc_q   <= '0;
      z_q     <= 1'b1;
      c_q     <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < NREG; i++)
        regs_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          if (instr_valid) begin
            op_q    <= opcode;
            sel_q   <= reg_sel;
            imm_q   <= imm;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (wr_acc) begin
            acc_q <= res_d;
            z_q   <= (res_d == '0);
          end
          if (wr_c)
            c_q <= c_d;
          if (wr_reg)
            regs_q[sel_q] <= acc_q;
          done_q  <= 1'b1;
          err_q   <= ill;
          state_q <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_minirisc_core.sv
// Directed bench for minirisc_core (DATA_W=8, NREG=4).
// Build with +define+MINIRISC_MUL_EN to cover the multiplier path.
module tb_minirisc_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] opcode;
  logic [1:0] reg_sel;
  logic [7:0] imm;
  logic [7:0] acc;
  logic       flag_z;
  logic       flag_c;
  logic       done;
  logic       err;
  logic [1:0] state;

  int n_cmp = 0;
  int n_err = 0;

  minirisc_core #(.DATA_W(8), .NREG(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .reg_sel     (reg_sel),
    .imm         (imm),
    .acc         (acc),
    .flag_z      (flag_z),
    .flag_c      (flag_c),
    .done        (done),
    .err         (err),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full instruction with handshake/latency checks.
  task automatic exec(input logic [3:0] op,
                      input logic [1:0] sel,
                      input logic [7:0] im,
                      input logic       exp_err);
    @(negedge clk);
    instr_valid = 1'b1;
    opcode      = op;
    reg_sel     = sel;
    imm         = im;
    tick();
    chk("exec_state", state, 2'd1);
    chk("exec_ready", instr_ready, 1'b0);
    chk("exec_done0", done, 1'b0);
    @(negedge clk);
    instr_valid = 1'b0;
    tick();
    chk("done_state", state, 2'd2);
    chk("done_pulse", done, 1'b1);
    chk("done_err", err, exp_err);
    tick();
    chk("back_idle", state, 2'd0);
    chk("done_clr", done, 1'b0);
    chk("err_clr", err, 1'b0);
  endtask

  task automatic chk_arch(input string tag,
                          input logic [7:0] a,
                          input logic z,
                          input logic c);
    chk({tag, "_acc"}, acc, a);
    chk({tag, "_z"}, flag_z, z);
    chk({tag, "_c"}, flag_c, c);
  endtask

  initial begin
    rst         = 1'b1;
    instr_valid = 1'b0;
    opcode      = 4'h0;
    reg_sel     = 2'd0;
    imm         = 8'h00;
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_state", state, 2'd0);
    chk("rst_ready", instr_ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk_arch("rst", 8'h00, 1'b1, 1'b0);

    // idle with valid low: nothing moves
    tick();
    chk("idle_hold", state, 2'd0);

    exec(4'h1, 2'd0, 8'h7F, 1'b0);
    exec(4'h2, 2'd0, 8'h01, 1'b0);
    chk_arch("addi", 8'h80, 1'b0, 1'b0);

    exec(4'h1, 2'd0, 8'hFF, 1'b0);
    exec(4'h7, 2'd0, 8'h00, 1'b0);
    chk_arch("inc", 8'h00, 1'b1, 1'b1);
    exec(4'h8, 2'd0, 8'h00, 1'b0);
    chk_arch("dec", 8'hFF, 1'b0, 1'b1);

    exec(4'h1, 2'd0, 8'h5A, 1'b0);
    exec(4'h4, 2'd2, 8'h00, 1'b0);
    exec(4'h1, 2'd0, 8'h00, 1'b0);
    exec(4'h5, 2'd2, 8'h00, 1'b0);
    chk_arch("ldr2", 8'h5A, 1'b0, 1'b1);
    exec(4'h6, 2'd2, 8'h00, 1'b0);
    chk_arch("addr", 8'hB4, 1'b0, 1'b0);
    exec(4'h5, 2'd0, 8'h00, 1'b0);
    chk_arch("ldr0", 8'h00, 1'b1, 1'b0);
    exec(4'h5, 2'd1, 8'h00, 1'b0);
    chk("ldr1_acc", acc, 8'h00);
    exec(4'h5, 2'd3, 8'h00, 1'b0);
    chk("ldr3_acc", acc, 8'h00);

    // borrow and logic ops; logic ops keep flag_c
    exec(4'h1, 2'd0, 8'h05, 1'b0);
    exec(4'h3, 2'd0, 8'h06, 1'b0);
    chk_arch("subi", 8'hFF, 1'b0, 1'b1);
    exec(4'h9, 2'd0, 8'h0F, 1'b0);
    chk_arch("andi", 8'h0F, 1'b0, 1'b1);
    exec(4'hA, 2'd0, 8'hF0, 1'b0);
    chk_arch("ori", 8'hFF, 1'b0, 1'b1);
    exec(4'hB, 2'd0, 8'hFF, 1'b0);
    chk_arch("xori", 8'h00, 1'b1, 1'b1);
    exec(4'h0, 2'd0, 8'h55, 1'b0);
    chk_arch("nop", 8'h00, 1'b1, 1'b1);

    // valid held high, fields changing mid-flight
    exec(4'h1, 2'd0, 8'h33, 1'b0);
    @(negedge clk);
    instr_valid = 1'b1;
    opcode      = 4'h2;
    imm         = 8'h01;
    tick();
    chk("hold_ready_e", instr_ready, 1'b0);
    @(negedge clk);
    opcode = 4'h1;
    imm    = 8'hAA;
    tick();
    chk("hold_ready_d", instr_ready, 1'b0);
    chk("hold_done", done, 1'b1);
    @(negedge clk);
    instr_valid = 1'b0;
    tick();
    chk("hold_idle", state, 2'd0);
    chk_arch("hold", 8'h34, 1'b0, 1'b0);

    exec(4'hE, 2'd0, 8'h12, 1'b1);
    chk_arch("ill", 8'h34, 1'b0, 1'b0);

    // reset during EXEC discards the instruction
    @(negedge clk);
    instr_valid = 1'b1;
    opcode      = 4'h1;
    imm         = 8'h10;
    tick();
    chk("rexec_state", state, 2'd1);
    @(negedge clk);
    instr_valid = 1'b0;
    rst         = 1'b1;
    tick();
    chk("rexec_done", done, 1'b0);
    chk("rexec_st", state, 2'd0);
    chk_arch("rexec", 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("rexec_after", done, 1'b0);

    exec(4'h1, 2'd0, 8'h10, 1'b0);
`ifdef MINIRISC_MUL_EN
    exec(4'hC, 2'd0, 8'h20, 1'b0);
    chk_arch("muli", 8'h00, 1'b1, 1'b1);
`else
    exec(4'hC, 2'd0, 8'h20, 1'b1);
    chk_arch("muli_ill", 8'h10, 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
